// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the memory/writeback boundary. These are used by the
// writeback stage, the decoder (which produces wb_sel) and the hazard unit.
//   DATA_W_DEF / BYTE_W_DEF / RD_W_DEF : default datapath, pixel-byte and
//                                        register-index widths
//   wb_sel_e                           : writeback data-source encoding
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int BYTE_W_DEF = 8;
    localparam int RD_W_DEF   = 4;

    // Writeback data source. The decoder emits these codes directly.
    typedef enum logic [1:0] {
        WB_SEL_ALU    = 2'b00,   // ALU result
        WB_SEL_WORD   = 2'b01,   // full DataMemory word (Do)
        WB_SEL_BYTE_Z = 2'b10,   // pixel byte (Dob), zero-extended
        WB_SEL_BYTE_S = 2'b11    // pixel byte (Dob), sign-extended
    } wb_sel_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_if
// Bundle of everything crossing into and out of the writeback stage apart from
// clock and reset.
//   From memory stage / hazard unit : stall, flush, valid_in, alu_result_in,
//                                     rd_in, reg_we_in, wb_sel_in
//   From DataMemory                 : mem_do, mem_dob
//   To register file / forwarding   : wb_we, wb_rd, wb_data,
//                                     fwd_valid, fwd_rd, fwd_data
// Modports:
//   master : the upstream side (drives the stage inputs, sees its outputs)
//   slave  : the writeback stage itself
// -----------------------------------------------------------------------------
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int RD_W   = RD_W_DEF
);

    logic              stall;
    logic              flush;
    logic              valid_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [RD_W-1:0]   rd_in;
    logic              reg_we_in;
    logic [1:0]        wb_sel_in;
    logic [DATA_W-1:0] mem_do;
    logic [BYTE_W-1:0] mem_dob;

    logic              wb_we;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              fwd_valid;
    logic [RD_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output stall, flush, valid_in, alu_result_in, rd_in, reg_we_in,
               wb_sel_in, mem_do, mem_dob,
        input  wb_we, wb_rd, wb_data, fwd_valid, fwd_rd, fwd_data
    );

    modport slave (
        input  stall, flush, valid_in, alu_result_in, rd_in, reg_we_in,
               wb_sel_in, mem_do, mem_dob,
        output wb_we, wb_rd, wb_data, fwd_valid, fwd_rd, fwd_data
    );

endinterface

// File: rtl/mem_wb_stage_wb_select.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_wb_select
// Combinational writeback source select with pixel-byte extension.
//   sel_i  : wb_sel_e source code
//   alu_i  : ALU result
//   do_i   : DataMemory word
//   dob_i  : DataMemory pixel byte
//   data_o : value to write back
// Pure wiring and muxing; no arithmetic.
// -----------------------------------------------------------------------------
module mem_wb_stage_wb_select
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  wb_sel_e           sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] do_i,
    input  logic [BYTE_W-1:0] dob_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] byte_zext;
    logic [DATA_W-1:0] byte_sext;

    // Low bits of both extensions are the byte itself; upper bits are either
    // zero or copies of the byte's top bit.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ext
            if (gi < BYTE_W) begin : g_low
                assign byte_zext[gi] = dob_i[gi];
                assign byte_sext[gi] = dob_i[gi];
            end else begin : g_high
                assign byte_zext[gi] = 1'b0;
                assign byte_sext[gi] = dob_i[BYTE_W-1];
            end
        end
    endgenerate

    always_comb begin
        data_o = alu_i;
        case (sel_i)
            WB_SEL_ALU:    data_o = alu_i;
            WB_SEL_WORD:   data_o = do_i;
            WB_SEL_BYTE_Z: data_o = byte_zext;
            WB_SEL_BYTE_S: data_o = byte_sext;
            default:       data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Writeback stage sitting right after the memory stage. DataMemory reads are
// synchronous, so the word/byte for an instruction appears one cycle after its
// address. Rank A captures the instruction's control and ALU result; rank B
// captures that control one cycle later together with the selected writeback
// value, lining control up with the memory data.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high (wins over stall and flush)
//   bus : mem_wb_stage_if.slave
//         inputs  stall, flush, valid_in, alu_result_in, rd_in, reg_we_in,
//                 wb_sel_in, mem_do, mem_dob
//         outputs wb_we, wb_rd, wb_data and forwarding copies fwd_*
//
// Stall handling: both ranks freeze. DataMemory output is not guaranteed to
// stay put while stalled, so on the first stalled cycle with a live rank-A
// instruction the memory data is parked in hold registers and rank B takes
// it from there when the stall releases.
// -----------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);

    // Rank A
    logic              a_valid_q,  a_valid_d;
    logic [DATA_W-1:0] a_alu_q,    a_alu_d;
    logic [RD_W-1:0]   a_rd_q,     a_rd_d;
    logic              a_reg_we_q, a_reg_we_d;
    wb_sel_e           a_wb_sel_q, a_wb_sel_d;

    // Parked memory data for a stalled rank-A instruction
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_do_q,    hold_do_d;
    logic [BYTE_W-1:0] hold_dob_q,   hold_dob_d;

    // Rank B (drives the register-file write port)
    logic              b_valid_q,  b_valid_d;
    logic              b_reg_we_q, b_reg_we_d;
    logic [RD_W-1:0]   b_rd_q,     b_rd_d;
    logic [DATA_W-1:0] b_data_q,   b_data_d;

    logic [DATA_W-1:0] src_do;
    logic [BYTE_W-1:0] src_dob;
    logic [DATA_W-1:0] sel_data;

    // Once parked, the hold copy is the authoritative memory data for the
    // instruction in rank A; the live bus may already belong to something else.
    always_comb begin
        src_do  = hold_valid_q ? hold_do_q  : bus.mem_do;
        src_dob = hold_valid_q ? hold_dob_q : bus.mem_dob;
    end

    mem_wb_stage_wb_select #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_wb_select (
        .sel_i  (a_wb_sel_q),
        .alu_i  (a_alu_q),
        .do_i   (src_do),
        .dob_i  (src_dob),
        .data_o (sel_data)
    );

    always_comb begin
        a_valid_d    = a_valid_q;
        a_alu_d      = a_alu_q;
        a_rd_d       = a_rd_q;
        a_reg_we_d   = a_reg_we_q;
        a_wb_sel_d   = a_wb_sel_q;
        hold_valid_d = hold_valid_q;
        hold_do_d    = hold_do_q;
        hold_dob_d   = hold_dob_q;
        b_valid_d    = b_valid_q;
        b_reg_we_d   = b_reg_we_q;
        b_rd_d       = b_rd_q;
        b_data_d     = b_data_q;

        if (!bus.stall) begin
            a_valid_d  = bus.valid_in & ~bus.flush;
            a_alu_d    = bus.alu_result_in;
            a_rd_d     = bus.rd_in;
            a_reg_we_d = bus.reg_we_in;
            a_wb_sel_d = wb_sel_e'(bus.wb_sel_in);

            b_valid_d  = a_valid_q;
            // Bubbles leave index and data untouched so the outputs keep
            // their last written values.
            if (a_valid_q) begin
                b_reg_we_d = a_reg_we_q;
                b_rd_d     = a_rd_q;
                b_data_d   = sel_data;
            end
            // Rank B consumes any parked data on this edge.
            hold_valid_d = 1'b0;
        end else if (bus.flush) begin
            // Killed while frozen: rank A keeps its fields but becomes a
            // bubble, and its parked data is discarded with it.
            a_valid_d    = 1'b0;
            hold_valid_d = 1'b0;
        end else if (a_valid_q && !hold_valid_q) begin
            // First stalled cycle: park memory data once; later stall cycles
            // leave the parked copy alone.
            hold_valid_d = 1'b1;
            hold_do_d    = bus.mem_do;
            hold_dob_d   = bus.mem_dob;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q    <= 1'b0;
            a_alu_q      <= '0;
            a_rd_q       <= '0;
            a_reg_we_q   <= 1'b0;
            a_wb_sel_q   <= WB_SEL_ALU;
            hold_valid_q <= 1'b0;
            hold_do_q    <= '0;
            hold_dob_q   <= '0;
            b_valid_q    <= 1'b0;
            b_reg_we_q   <= 1'b0;
            b_rd_q       <= '0;
            b_data_q     <= '0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_alu_q      <= a_alu_d;
            a_rd_q       <= a_rd_d;
            a_reg_we_q   <= a_reg_we_d;
            a_wb_sel_q   <= a_wb_sel_d;
            hold_valid_q <= hold_valid_d;
            hold_do_q    <= hold_do_d;
            hold_dob_q   <= hold_dob_d;
            b_valid_q    <= b_valid_d;
            b_reg_we_q   <= b_reg_we_d;
            b_rd_q       <= b_rd_d;
            b_data_q     <= b_data_d;
        end
    end

    // Write enable stays up through a stall: rewriting the same value is
    // harmless and keeps the forwarding source visible to the hazard unit.
    assign bus.wb_we     = b_valid_q & b_reg_we_q;
    assign bus.wb_rd     = b_rd_q;
    assign bus.wb_data   = b_data_q;
    assign bus.fwd_valid = b_valid_q & b_reg_we_q;
    assign bus.fwd_rd    = b_rd_q;
    assign bus.fwd_data  = b_data_q;

endmodule
